reaction_round_ctrl: RTL and testbench

//  Sequences one reaction-time round at a time: arms the random delay, lights green, measures
//  the reaction time in 1 ms ticks, and commits the result to the 8x13 register file.

---
 rtl/reaction_pkg.sv | 25 ++
 rtl/reaction_delay_gen.sv | 45 ++++
 rtl/reaction_round_ctrl.sv | 123 ++++++++++++
 tb/tb_reaction_round_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared widths, limits and FSM encodings for the reaction-time round controller.
package reaction_pkg;

    localparam int SCORE_W = 13;
    localparam int DELAY_W = 11;

    localparam logic [SCORE_W-1:0] MAX_SCORE   = 13'd8191;
    localparam logic [SCORE_W-1:0] FOUL_HOLD   = 13'd500;
    localparam logic [DELAY_W-1:0] FIXED_DELAY = 11'd1500;
    localparam logic [DELAY_W-1:0] MIN_DELAY   = 11'd1000;

    localparam logic [2:0] RUN_COUNT_ADDR = 3'd0;
    localparam logic [2:0] NUM_SLOTS      = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DELAY    = 3'd1,
        S_ARMED    = 3'd2,
        S_WR_SCORE = 3'd3,
        S_WR_COUNT = 3'd4,
        S_FOUL     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/reaction_delay_gen.sv
// Loadable 1 ms down-counter for the pre-green delay; o_done is high while the count is zero.
// RANDOM_DELAY_EN adds a free-running 11-bit LFSR that randomises the loaded delay.
module reaction_delay_gen
    import reaction_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_tick,
    output logic o_done
);

    logic [DELAY_W-1:0] r_cnt;
    logic [DELAY_W-1:0] w_load_val;

`ifdef RANDOM_DELAY_EN
    logic [10:0] r_lfsr;

    // x^11 + x^9 + 1, advanced every clock so the press timing picks the delay
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= 11'h001;
        end else begin
            r_lfsr <= {r_lfsr[9:0], r_lfsr[10] ^ r_lfsr[8]};
        end
    end

    assign w_load_val = MIN_DELAY + {1'b0, r_lfsr[9:0]};
`else
    assign w_load_val = FIXED_DELAY;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= w_load_val;
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/reaction_round_ctrl.sv
// One reaction round at a time: delay, green, time the hit in ms ticks, commit score then run count.
// RANDOM_DELAY_EN (in reaction_delay_gen) selects a random rather than fixed pre-green delay.
module reaction_round_ctrl
    import reaction_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick_1khz,
    input  logic               i_start_pulse,
    input  logic               i_hit_pulse,
    output logic               o_green_led,
    output logic               o_red_led,
    output logic               o_rf_we,
    output logic [2:0]         o_rf_wa,
    output logic [SCORE_W-1:0] o_rf_wd,
    output logic [2:0]         o_run_count,
    output logic [SCORE_W-1:0] o_last_score,
    output logic [SCORE_W-1:0] o_best_score,
    output logic [2:0]         o_state
);

    state_t             r_state;
    state_t             w_next;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_last;
    logic [SCORE_W-1:0] r_best;
    logic [2:0]         r_run_count;
    logic [2:0]         w_run_next;
    logic               w_load;
    logic               w_delay_done;

    assign w_run_next = r_run_count + 3'd1;
    assign w_load     = (r_state == S_IDLE) && i_start_pulse;

    reaction_delay_gen u_delay (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_tick (i_tick_1khz),
        .o_done (w_delay_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (i_start_pulse) w_next = S_DELAY;
            S_DELAY: begin
                if (i_hit_pulse)       w_next = S_FOUL;
                else if (w_delay_done) w_next = S_ARMED;
            end
            S_ARMED:    if (i_hit_pulse || (r_score == MAX_SCORE)) w_next = S_WR_SCORE;
            S_WR_SCORE: w_next = S_WR_COUNT;
            S_WR_COUNT: w_next = (w_run_next == NUM_SLOTS) ? S_DONE : S_IDLE;
            S_FOUL:     if (r_score == FOUL_HOLD) w_next = S_IDLE;
            S_DONE:     w_next = S_DONE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_green_led = 1'b0;
        o_red_led   = 1'b0;
        o_rf_we     = 1'b0;
        o_rf_wa     = 3'd0;
        o_rf_wd     = '0;
        case (r_state)
            S_ARMED: o_green_led = 1'b1;
            S_FOUL,
            S_DONE:  o_red_led = 1'b1;
            S_WR_SCORE: begin
                o_rf_we = 1'b1;
                o_rf_wa = w_run_next;
                o_rf_wd = r_score;
            end
            S_WR_COUNT: begin
                o_rf_we = 1'b1;
                o_rf_wa = RUN_COUNT_ADDR;
                o_rf_wd = {{(SCORE_W-3){1'b0}}, w_run_next};
            end
            default: ;
        endcase
    end

    // r_score times the reaction in ARMED and the red hold in FOUL; a hit freezes it before any tick
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_score     <= '0;
            r_last      <= '0;
            r_best      <= MAX_SCORE;
            r_run_count <= 3'd0;
        end else begin
            if (w_load || ((r_state == S_DELAY) && i_hit_pulse)) begin
                r_score <= '0;
            end else if ((((r_state == S_ARMED) && !i_hit_pulse) || (r_state == S_FOUL))
                         && i_tick_1khz && (r_score != MAX_SCORE)) begin
                r_score <= r_score + 1'b1;
            end
            if (r_state == S_WR_SCORE) begin
                r_last <= r_score;
                if ((r_score < MAX_SCORE) && (r_score < r_best)) begin
                    r_best <= r_score;
                end
            end
            if (r_state == S_WR_COUNT) begin
                r_run_count <= w_run_next;
            end
        end
    end

    assign o_run_count  = r_run_count;
    assign o_last_score = r_last;
    assign o_best_score = r_best;
    assign o_state      = r_state;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl: timeout, hit timing, fouls, seven-round fill and reset.
module tb_reaction_round_ctrl;

    logic        clk = 1'b0;
    logic        rst, tick, start, hit;
    logic        green, red, rf_we;
    logic [2:0]  rf_wa, run_count, state;
    logic [12:0] rf_wd, last_score, best_score;

    int n_checks = 0;
    int n_errors = 0;
    logic we_seen;
    logic [10:0] m_lfsr;

    always #5 clk = ~clk;

    reaction_round_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tick_1khz  (tick),
        .i_start_pulse(start),
        .i_hit_pulse  (hit),
        .o_green_led  (green),
        .o_red_led    (red),
        .o_rf_we      (rf_we),
        .o_rf_wa      (rf_wa),
        .o_rf_wd      (rf_wd),
        .o_run_count  (run_count),
        .o_last_score (last_score),
        .o_best_score (best_score),
        .o_state      (state)
    );

    // Reference LFSR: x^11+x^9+1, seed 1 on reset, one step per clock
    always @(posedge clk) begin
        if (rst) m_lfsr <= 11'h001;
        else     m_lfsr <= {m_lfsr[9:0], m_lfsr[10] ^ m_lfsr[8]};
    end

    typedef struct {
        int          score;
        logic [12:0] best;
        logic [2:0]  state_after;
    } round_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic s, input logic h);
        tick = t; start = s; hit = h;
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; hit = 1'b0;
        if (rf_we) we_seen = 1'b1;
    endtask

    task automatic tk();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_only(output int de);
`ifdef RANDOM_DELAY_EN
        de = 1000 + int'(m_lfsr[9:0]);
`else
        de = 1500;
`endif
        cyc(1'b0, 1'b1, 1'b0);
        chk("state_delay_after_start", state, 1);
    endtask

    task automatic wait_green(input int de);
        int d;
        d = 0;
        while (!green && d < 2100) begin
            tk();
            d++;
        end
        chk("delay_ticks", d, de);
`ifdef RANDOM_DELAY_EN
        chk("delay_in_range", (d >= 1000 && d <= 2023), 1);
`endif
    endtask

    // Called right after the cycle that should have entered WR_SCORE
    task automatic commit(input int sc, input int slot, input logic [2:0] st_after);
        chk("wr_score_we", rf_we, 1);
        chk("wr_score_wa", rf_wa, slot);
        chk("wr_score_wd", rf_wd, sc);
        cyc(1'b0, 1'b0, 1'b0);
        chk("wr_count_we", rf_we, 1);
        chk("wr_count_wa", rf_wa, 0);
        chk("wr_count_wd", rf_wd, slot);
        cyc(1'b0, 1'b0, 1'b0);
        chk("post_commit_we", rf_we, 0);
        chk("run_count", run_count, slot);
        chk("last_score", last_score, sc);
        chk("state_after_commit", state, st_after);
    endtask

    task automatic foul_wait(input int rc);
        int n;
        n = 0;
        we_seen = 1'b0;
        while (state == 3'd5 && n < 600) begin
            tk();
            n++;
        end
        chk("foul_hold_ticks", n, 500);
        chk("foul_no_write", we_seen, 0);
        chk("foul_run_count", run_count, rc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        round_vec_t vecs[7];
        int de, n;
        vecs[0] = '{300, 13'd300, 3'd0};
        vecs[1] = '{200, 13'd200, 3'd0};
        vecs[2] = '{400, 13'd200, 3'd0};
        vecs[3] = '{150, 13'd150, 3'd0};
        vecs[4] = '{500, 13'd150, 3'd0};
        vecs[5] = '{250, 13'd150, 3'd0};
        vecs[6] = '{350, 13'd150, 3'd6};

        tick = 1'b0; start = 1'b0; hit = 1'b0; we_seen = 1'b0;
        do_reset();
        chk("rst_state", state, 0);
        chk("rst_best", best_score, 8191);
        chk("rst_last", last_score, 0);
        chk("rst_run", run_count, 0);
        chk("rst_leds", {green, red}, 0);
        chk("rst_rf", {rf_we, rf_wa, rf_wd}, 0);

        cyc(1'b0, 1'b0, 1'b1);
        chk("hit_in_idle_ignored", state, 0);

        // Timeout: no hit, count saturates at 8191
        start_only(de);
        wait_green(de);
        n = 0;
        while (!rf_we && n < 8300) begin
            tk();
            n++;
        end
        chk("timeout_ticks", n, 8191);
        commit(8191, 1, 3'd0);
        chk("timeout_best_unchanged", best_score, 8191);

        // Hit 250 ticks after green
        start_only(de);
        wait_green(de);
        chk("green_led", green, 1);
        repeat (250) tk();
        cyc(1'b0, 1'b0, 1'b1);
        commit(250, 2, 3'd0);
        chk("best_250", best_score, 250);

        // Hit during DELAY, and a start during FOUL is ignored
        start_only(de);
        repeat (100) tk();
        cyc(1'b0, 1'b0, 1'b1);
        chk("foul_state", state, 5);
        chk("foul_red", red, 1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("start_in_foul_ignored", state, 5);
        foul_wait(2);

        // Hit in the same cycle the delay expires: foul wins
        start_only(de);
        repeat (de - 1) tk();
        cyc(1'b1, 1'b0, 1'b0);
        chk("delay_zero_not_yet_armed", state, 1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("hit_beats_expiry", state, 5);
        foul_wait(2);

        // Reset during ARMED
        start_only(de);
        wait_green(de);
        repeat (40) tk();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("armed_rst_state", state, 0);
        chk("armed_rst_green", green, 0);
        chk("armed_rst_run", run_count, 0);
        chk("armed_rst_best", best_score, 8191);
        chk("armed_rst_last", last_score, 0);

        // Hit and tick together at count 99
        start_only(de);
        wait_green(de);
        repeat (99) tk();
        cyc(1'b1, 1'b0, 1'b1);
        commit(99, 1, 3'd0);
        chk("best_99", best_score, 99);

        // Seven rounds from reset fill every slot and end in DONE
        do_reset();
        for (int i = 0; i < 7; i++) begin
            start_only(de);
            wait_green(de);
            repeat (vecs[i].score) tk();
            cyc(1'b0, 1'b0, 1'b1);
            commit(vecs[i].score, i + 1, vecs[i].state_after);
            chk("table_best", best_score, vecs[i].best);
        end
        chk("done_red", red, 1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("done_ignores_start", state, 6);
        we_seen = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        chk("done_ignores_hit", state, 6);
        chk("done_no_write", we_seen, 0);
        chk("done_run_count", run_count, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
